// File: rtl/mc_decoder_pkg.sv
// Shared types and constants for the multicycle control unit: state encoding,
// data-processing cmd field values and the ALU control codes.
package mc_decoder_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        MULEX,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;

endpackage

// File: rtl/mc_decoder_if.sv
// Bundle between the instruction register fields and the datapath controls.
// No valid/ready handshake: fields are sampled every cycle and all controls are
// combinational from the decoder state; state is exported for observation.
interface mc_decoder_if #(
    parameter int ALUCTRL_W = 3
);
    import mc_decoder_pkg::*;

    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic                 IsMul;

    logic [1:0]           FlagW;
    logic                 PCS;
    logic                 NextPC;
    logic                 RegW;
    logic                 MemW;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    state_t               state;

    modport master (
        output Op, Funct, Rd, IsMul,
        input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, state
    );

    modport slave (
        input  Op, Funct, Rd, IsMul,
        output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, state
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps cmd/S to ALUControl and FlagW while ALUOp is
// high, and flags commands whose result must not be written back.
module mc_alu_decoder
    import mc_decoder_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 alu_op,
    input  logic [5:0]           funct,
    input  logic                 mul_active,
    input  logic                 mul_last,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           flag_w,
    output logic                 no_write
);

    logic [3:0] cmd;
    logic       s_bit;
    logic [2:0] code;
    logic       supported;
    logic       force_nz;
    logic       arith;
    logic       nz_w;
    logic       unused_i_bit;

    assign cmd          = funct[4:1];
    assign s_bit        = funct[0];
    assign unused_i_bit = funct[5];

    always_comb begin
        code      = ALU_ADD;
        supported = 1'b1;
        force_nz  = 1'b0;
        arith     = 1'b0;
        no_write  = 1'b0;
        case (cmd)
            CMD_ADD: begin code = ALU_ADD; arith = 1'b1; end
            CMD_SUB: begin code = ALU_SUB; arith = 1'b1; end
            CMD_AND: code = ALU_AND;
            CMD_ORR: code = ALU_ORR;
            CMD_EOR: code = ALU_EOR;
            CMD_MOV: code = ALU_MOV;
            CMD_CMP: begin code = ALU_SUB; arith = 1'b1; force_nz = 1'b1; no_write = 1'b1; end
            CMD_TST: begin code = ALU_AND; force_nz = 1'b1; no_write = 1'b1; end
            default: begin code = ALU_ADD; supported = 1'b0; no_write = 1'b1; end
        endcase
    end

    // no_write ignores alu_op so the writeback state can still consult it.
    always_comb begin
        alu_control = '0;
        flag_w      = 2'b00;
        nz_w        = 1'b0;
        if (alu_op) begin
            if (mul_active) begin
                alu_control = ALUCTRL_W'(ALU_MUL);
                flag_w      = {mul_last & s_bit, 1'b0};
            end else begin
                alu_control = ALUCTRL_W'(code);
                nz_w        = supported & (s_bit | force_nz);
                flag_w      = {nz_w, nz_w & arith};
            end
        end
    end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle control unit: main FSM, optional multiply-execute state with its
// cycle counter (MC_DECODER_MUL_EN), PC write logic and instruction decoder.
module mc_decoder
    import mc_decoder_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int MUL_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    mc_decoder_if.slave  dec
);

    state_t               state_q, state_d;
    logic                 alu_op;
    logic                 branch;
    logic                 reg_w;
    logic                 no_write;
    logic                 mul_active;
    logic                 mul_last;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [1:0]           flag_w;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

`ifdef MC_DECODER_MUL_EN
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    // Counter idles at zero outside MULEX, so every entry starts from zero.
    always_comb begin
        mul_cnt_d = '0;
        if (state_q == MULEX) mul_cnt_d = mul_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) mul_cnt_q <= '0;
        else       mul_cnt_q <= mul_cnt_d;
    end

    assign mul_active = (state_q == MULEX);
    assign mul_last   = mul_active && (mul_cnt_q == CNT_W'(MUL_CYCLES - 1));
`else
    logic unused_is_mul;
    assign unused_is_mul = dec.IsMul;
    assign mul_active    = 1'b0;
    assign mul_last      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (dec.Op)
                    2'b01: state_d = MEMADR;
                    2'b10: state_d = BRANCH;
                    2'b00: begin
                        if (dec.Funct[5]) state_d = EXECI;
`ifdef MC_DECODER_MUL_EN
                        else if (dec.IsMul) state_d = MULEX;
`endif
                        else state_d = EXECR;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = dec.Funct[0] ? MEMREAD : MEMWR;
            MEMREAD: state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = FETCH;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            MULEX:   state_d = mul_last ? ALUWB : MULEX;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alu_op        = 1'b0;
        branch        = 1'b0;
        reg_w         = 1'b0;
        dec.NextPC    = 1'b0;
        dec.MemW      = 1'b0;
        dec.IRWrite   = 1'b0;
        dec.AdrSrc    = 1'b0;
        dec.ResultSrc = 2'b00;
        dec.ALUSrcA   = 2'b00;
        dec.ALUSrcB   = 2'b00;
        case (state_q)
            FETCH: begin
                dec.IRWrite   = 1'b1;
                dec.NextPC    = 1'b1;
                dec.ALUSrcA   = 2'b01;
                dec.ALUSrcB   = 2'b10;
                dec.ResultSrc = 2'b10;
            end
            DECODE: begin
                dec.ALUSrcA   = 2'b01;
                dec.ALUSrcB   = 2'b10;
                dec.ResultSrc = 2'b10;
            end
            MEMADR:  dec.ALUSrcB = 2'b01;
            MEMREAD: dec.AdrSrc  = 1'b1;
            MEMWB: begin
                dec.ResultSrc = 2'b01;
                reg_w         = 1'b1;
            end
            MEMWR: begin
                dec.AdrSrc = 1'b1;
                dec.MemW   = 1'b1;
            end
            EXECR, MULEX: alu_op = 1'b1;
            EXECI: begin
                alu_op      = 1'b1;
                dec.ALUSrcB = 2'b01;
            end
            ALUWB: reg_w = ~no_write;
            BRANCH: begin
                dec.ALUSrcA   = 2'b10;
                dec.ALUSrcB   = 2'b01;
                dec.ResultSrc = 2'b10;
                branch        = 1'b1;
            end
            default: ;
        endcase
    end

    mc_alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (dec.Funct),
        .mul_active  (mul_active),
        .mul_last    (mul_last),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .no_write    (no_write)
    );

    assign dec.RegW       = reg_w;
    assign dec.PCS        = ((dec.Rd == 4'hF) & reg_w) | branch;
    assign dec.ALUControl = alu_control;
    assign dec.FlagW      = flag_w;
    assign dec.ImmSrc     = dec.Op;
    assign dec.RegSrc     = {dec.Op == 2'b01, dec.Op == 2'b10};
    assign dec.state      = state_q;

endmodule
